pkt_demux1to16: RTL and testbench
=================================

Name: pkt_demux1to16

Overview:
- Write-side packet distributor: takes one sop/eop/vld-framed packet stream and routes each whole packet to one of `IN_PORT_NUM per-port write interfaces.
- Destination is sampled on the sop beat and held for the rest of the packet.
- Performs the reverse function of the read-side 16:1 port selector in the cache datapath.
- One registered output stage with per-port ready backpressure, plus protocol-error detection and counting.

Parameters:
- PORT_NUM, `IN_PORT_NUM (16): number of output ports.
- DATA_WIDTH, `DATA_WIDTH: beat width.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_vld  in  1  input beat valid.
- i_wr_sop  in  1  first beat of packet.
- i_wr_eop  in  1  last beat of packet.
- i_wr_dst  in  $clog2(PORT_NUM)  destination port; sampled only on an accepted sop beat.
- i_wr_data  in  DATA_WIDTH  beat data.
- o_wr_rdy  out  1  input may be accepted this cycle.
- o_port_vld  out  [PORT_NUM-1:0]  per-port valid; at most one bit set.
- o_port_sop  out  [PORT_NUM-1:0]  per-port sop.
- o_port_eop  out  [PORT_NUM-1:0]  per-port eop.
- o_port_data  out  DATA_WIDTH x [PORT_NUM-1:0]  per-port data; unpacked array.
- i_port_rdy  in  [PORT_NUM-1:0]  per-port ready.
- o_err  out  1  one-cycle pulse on a protocol error.
- o_err_cnt  out  ERR_CNT_W  saturating error count.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: all o_port_* = 0, o_err = 0, o_err_cnt = 0, state = IDLE, latched dst = 0, output stage empty.
- Reset mid-packet: the in-flight beat and the packet are discarded. No eop is emitted.
- Accept condition: a beat is accepted when i_wr_vld && o_wr_rdy.
- o_wr_rdy = !stage_vld || i_port_rdy[stage_dst]. This is combinational from the registered stage, so a new beat can be accepted in the same cycle the stage drains.
- Output stage:
  - An accepted beat that is forwarded is registered into the output stage: 1-cycle latency.
  - Only port stage_dst drives vld/sop/eop/data. All other ports output 0.
  - The stage holds its contents until i_port_rdy[stage_dst] = 1.
  - o_port_* are driven directly from the stage registers.
- State machine, transitions on accepted beats only:
  - IDLE:
    - sop, dst < PORT_NUM: latch dst and forward. Go to BUSY, or stay in IDLE if eop is also set (single-beat packet).
    - sop, dst >= PORT_NUM: possible only for non-power-of-2 PORT_NUM. Error; the beat is dropped. Go to DROP, or stay in IDLE if eop is also set.
    - no sop: error; the beat is dropped; stay in IDLE.
  - BUSY:
    - no sop: forward to the latched dst. eop returns to IDLE.
    - sop: error. The beat re-latches dst and is forwarded as the start of a new packet, so the previous packet is left unterminated downstream. Then follow the IDLE sop rules.
  - DROP: discard beats; o_wr_rdy is forced to 1. An eop beat returns to IDLE. A sop beat seen in DROP is an additional error.
- Error reporting:
  - o_err pulses for exactly one cycle, in the cycle after the offending accept.
  - o_err_cnt increments by 1 per error and saturates at all-ones.
  - Simultaneous errors are impossible: at most one beat is accepted per cycle.
- Invariants: sop and eop are forwarded unchanged, never synthesized. Data is never reordered.

Decomposition:
- Shared package mpcache_pkg: state enum (IDLE, BUSY, DROP), and PORT_W = $clog2(`IN_PORT_NUM).
- Sub-module pkt_out_stage: single-entry registered holding stage with dst and a ready-driven drain, instantiated once. It is separable and reusable.
- Target size: about 200 lines total.

Test Plan:
- 4-beat packet, dst=5, data 0x10..0x13, all ports ready: port 5 shows vld on cycles N+1..N+4, sop on the first beat, eop on the last; other ports stay 0; o_err stays 0.
- Single-beat packet (sop=eop=1), dst=15, followed next cycle by a sop to dst=0: port 15 gets one beat, then port 0 gets its packet one cycle later; no bubble.
- i_port_rdy[3]=0 for 3 cycles during a packet to dst=3: o_wr_rdy=0 while the stage is full; the stage data is held stable; the stream resumes with no beat lost or duplicated.
- Beat with vld=1, sop=0 in IDLE: dropped, no port vld, o_err pulses once, o_err_cnt = 1.
- sop to dst=7 arrives mid-packet (BUSY, dst=2): o_err pulses, the following beats go to port 7, o_err_cnt increments.
- Assert i_rst on beat 2 of a 4-beat packet: next cycle all outputs are 0 and o_err_cnt = 0; a fresh packet afterwards routes correctly.
- Preload o_err_cnt to 0xFFFF via repeated errors: a further error keeps it at 0xFFFF.

Source files
------------

// File: rtl/mpcache_pkg.sv
// mpcache_pkg: shared port count, widths and packet FSM states for the cache datapath
package mpcache_pkg;
  localparam int IN_PORT_NUM = 16;
  localparam int DATA_W_DEF = 32;
  localparam int PORT_W = $clog2(IN_PORT_NUM);
  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_e;
endpackage

// File: rtl/pkt_out_stage.sv
// pkt_out_stage: single-entry registered beat holder fanned out to one of PORT_NUM ports
module pkt_out_stage #(
  parameter int PORT_NUM = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load,
  input  logic                          i_sop,
  input  logic                          i_eop,
  input  logic [$clog2(PORT_NUM)-1:0]   i_dst,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [PORT_NUM-1:0]           i_port_rdy,
  output logic                          o_rdy,
  output logic [PORT_NUM-1:0]           o_port_vld,
  output logic [PORT_NUM-1:0]           o_port_sop,
  output logic [PORT_NUM-1:0]           o_port_eop,
  output logic [DATA_WIDTH-1:0]         o_port_data [PORT_NUM]
);
  localparam int DW = $clog2(PORT_NUM);
  logic vld_q, sop_q, eop_q;
  logic [DW-1:0] dst_q;
  logic [DATA_WIDTH-1:0] data_q;
  // load has priority: the parent only loads when o_rdy, i.e. empty or draining
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      dst_q <= '0;
      data_q <= '0;
    end else if (i_load) begin
      vld_q <= 1'b1;
      sop_q <= i_sop;
      eop_q <= i_eop;
      dst_q <= i_dst;
      data_q <= i_data;
    end else if (vld_q && i_port_rdy[dst_q]) begin
      vld_q <= 1'b0;
    end
  end
  assign o_rdy = !vld_q || i_port_rdy[dst_q];
  assign o_port_vld = PORT_NUM'(vld_q) << dst_q;
  assign o_port_sop = PORT_NUM'(vld_q && sop_q) << dst_q;
  assign o_port_eop = PORT_NUM'(vld_q && eop_q) << dst_q;
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) o_port_data[p] = (vld_q && dst_q == DW'(p)) ? data_q : '0;
  end
endmodule

// File: rtl/pkt_demux1to16.sv
// pkt_demux1to16: routes sop/eop-framed packets to one of PORT_NUM ports, with error detection
module pkt_demux1to16 import mpcache_pkg::*; #(
  parameter int PORT_NUM = IN_PORT_NUM,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ERR_CNT_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_vld,
  input  logic                          i_wr_sop,
  input  logic                          i_wr_eop,
  input  logic [$clog2(PORT_NUM)-1:0]   i_wr_dst,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  output logic                          o_wr_rdy,
  output logic [PORT_NUM-1:0]           o_port_vld,
  output logic [PORT_NUM-1:0]           o_port_sop,
  output logic [PORT_NUM-1:0]           o_port_eop,
  output logic [DATA_WIDTH-1:0]         o_port_data [PORT_NUM],
  input  logic [PORT_NUM-1:0]           i_port_rdy,
  output logic                          o_err,
  output logic [ERR_CNT_W-1:0]          o_err_cnt
);
  localparam int DW = $clog2(PORT_NUM);
  localparam bit POW2 = (1 << DW) == PORT_NUM;
  state_e state_q, state_d;
  logic [DW-1:0] dst_q;
  logic err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic stage_rdy, acc, dst_ok, fwd, err;
  assign o_wr_rdy = state_q == DROP || stage_rdy;
  // a sop while BUSY is flagged but still starts the new packet
  always_comb begin
    acc = i_wr_vld && o_wr_rdy;
    dst_ok = POW2 || int'(i_wr_dst) < PORT_NUM;
    fwd = acc && state_q != DROP && (i_wr_sop ? dst_ok : state_q == BUSY);
    err = acc && (state_q == DROP ? i_wr_sop : i_wr_sop ? (state_q == BUSY || !dst_ok) : state_q == IDLE);
    state_d = !acc ? state_q :
              state_q == DROP ? (i_wr_eop ? IDLE : DROP) :
              i_wr_eop ? IDLE :
              i_wr_sop ? (dst_ok ? BUSY : DROP) : state_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      dst_q <= '0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (fwd && i_wr_sop) dst_q <= i_wr_dst;
      err_q <= err;
      if (err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end
  assign o_err = err_q;
  assign o_err_cnt = err_cnt_q;
  pkt_out_stage #(.PORT_NUM(PORT_NUM), .DATA_WIDTH(DATA_WIDTH)) u_stage (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (fwd),
    .i_sop      (i_wr_sop),
    .i_eop      (i_wr_eop),
    .i_dst      (i_wr_sop ? i_wr_dst : dst_q),
    .i_data     (i_wr_data),
    .i_port_rdy (i_port_rdy),
    .o_rdy      (stage_rdy),
    .o_port_vld (o_port_vld),
    .o_port_sop (o_port_sop),
    .o_port_eop (o_port_eop),
    .o_port_data(o_port_data)
  );
endmodule

// File: tb/tb_pkt_demux1to16.sv
// tb_pkt_demux1to16: directed and random packet traffic checked against a behavioural model
module tb_pkt_demux1to16;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_wr_vld = 1'b0, i_wr_sop = 1'b0, i_wr_eop = 1'b0;
  logic [3:0] i_wr_dst = '0;
  logic [31:0] i_wr_data = '0;
  logic o_wr_rdy;
  logic [15:0] o_port_vld, o_port_sop, o_port_eop;
  logic [31:0] o_port_data [16];
  logic [15:0] i_port_rdy = '1;
  logic o_err;
  logic [15:0] o_err_cnt;
  int n_vec = 0, n_err = 0;
  int m_mode = 0, m_dst = 0, m_sdst = 0, m_cnt = 0;
  bit m_full = 0, m_ssop = 0, m_seop = 0, m_err = 0, last_acc = 0;
  logic [31:0] m_sdata = '0;
  pkt_demux1to16 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_vld(i_wr_vld), .i_wr_sop(i_wr_sop), .i_wr_eop(i_wr_eop),
    .i_wr_dst(i_wr_dst), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy), .o_port_vld(o_port_vld),
    .o_port_sop(o_port_sop), .o_port_eop(o_port_eop), .o_port_data(o_port_data),
    .i_port_rdy(i_port_rdy), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  // one clock: drive at negedge, update the model at posedge, compare at the next negedge
  task automatic step(input bit v, s, e, input int d, input logic [31:0] dat, input logic [15:0] pr, input bit r);
    bit exp_rdy, acc, drain, fwd, err;
    logic [15:0] exp_v;
    logic [31:0] orv;
    i_wr_vld = v; i_wr_sop = s; i_wr_eop = e; i_wr_dst = 4'(d); i_wr_data = dat;
    i_port_rdy = pr; i_rst = r;
    #1;
    exp_rdy = m_mode == 2 || !m_full || pr[m_sdst];
    if (!r) chk("wr_rdy", o_wr_rdy, exp_rdy);
    acc = v && exp_rdy && !r;
    last_acc = acc;
    @(posedge i_clk);
    if (r) begin
      m_mode = 0; m_dst = 0; m_sdst = 0; m_full = 0; m_ssop = 0; m_seop = 0; m_sdata = '0;
      m_err = 0; m_cnt = 0;
    end else begin
      drain = m_full && pr[m_sdst];
      fwd = 0; err = 0;
      if (acc) begin
        if (m_mode == 2) begin err = s; if (e) m_mode = 0; end
        else if (s) begin err = m_mode == 1; m_dst = d; fwd = 1; m_mode = e ? 0 : 1; end
        else if (m_mode == 1) begin fwd = 1; if (e) m_mode = 0; end
        else err = 1;
      end
      if (fwd) begin m_full = 1; m_sdst = m_dst; m_ssop = s; m_seop = e; m_sdata = dat; end
      else if (drain) m_full = 0;
      m_err = err;
      if (err && m_cnt < 65535) m_cnt++;
    end
    @(negedge i_clk);
    exp_v = m_full ? (16'd1 << m_sdst) : 16'd0;
    chk("port_vld", o_port_vld, exp_v);
    chk("port_sop", o_port_sop, m_ssop ? exp_v : 16'd0);
    chk("port_eop", o_port_eop, m_seop ? exp_v : 16'd0);
    chk("port_data", o_port_data[m_sdst], m_full ? m_sdata : 32'd0);
    orv = '0;
    for (int p = 0; p < 16; p++) if (p != m_sdst) orv |= o_port_data[p];
    chk("idle_data", orv, 32'd0);
    chk("err", o_err, m_err);
    chk("err_cnt", o_err_cnt, m_cnt);
  endtask
  // repeat a beat until accepted; port bp is held not-ready for the first nb tries
  task automatic send(input bit s, e, input int d, input logic [31:0] dat, input int nb, input int bp);
    for (int k = 0; k < 20; k++) begin
      step(1, s, e, d, dat, k < nb ? ~(16'd1 << bp) : 16'hFFFF, 0);
      if (last_acc) return;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    int len, pos, dst;
    bit s, e;
    @(negedge i_clk);
    step(0, 0, 0, 0, 0, '1, 1);
    step(0, 0, 0, 0, 0, '1, 1);
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, 5, 32'h10 + i, 0, 0);
    send(1, 1, 15, 32'hAA, 0, 0);
    for (int i = 0; i < 3; i++) send(i == 0, i == 2, 0, 32'h20 + i, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0);
    send(1, 0, 3, 32'h30, 0, 0);
    send(0, 0, 3, 32'h31, 3, 3);
    send(0, 0, 3, 32'h32, 0, 0);
    send(0, 1, 3, 32'h33, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0);
    send(0, 0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0);
    chk("stray_cnt", o_err_cnt, 32'd1);
    send(1, 0, 2, 32'h50, 0, 0);
    send(0, 0, 2, 32'h51, 0, 0);
    send(1, 0, 7, 32'h52, 0, 0);
    send(0, 1, 7, 32'h53, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0);
    chk("midsop_cnt", o_err_cnt, 32'd2);
    send(1, 0, 9, 32'h60, 0, 0);
    step(1, 0, 0, 9, 32'h61, '1, 1);
    chk("rst_cnt", o_err_cnt, 32'd0);
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, 12, 32'h70 + i, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0);
    len = 1; pos = 0; dst = 0;
    for (int c = 0; c < 3000; c++) begin
      s = pos == 0; e = pos == len - 1;
      if ($urandom_range(0, 24) == 0) s = ~s;
      step($urandom_range(0, 9) < 8, s, e, dst, $urandom, 16'($urandom | $urandom), $urandom_range(0, 399) == 0);
      if (i_rst) pos = 0;
      else if (last_acc) begin
        pos++;
        if (pos >= len) begin pos = 0; len = $urandom_range(1, 5); dst = $urandom_range(0, 15); end
      end
    end
    step(0, 0, 0, 0, 0, '1, 1);
    for (int i = 0; i < 65535; i++) step(1, 0, 0, 0, 32'(i), '1, 0);
    chk("sat_cnt", o_err_cnt, 32'hFFFF);
    step(1, 0, 0, 0, 0, '1, 0);
    chk("sat_hold", o_err_cnt, 32'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
